mem_arbiter: RTL and testbench

Two-requester memory-port arbiter placed between the core's instruction-fetch and load/store units and the single AXI-lite master port that feeds the MMU. It accepts one request at a time from either requester, sequences the single-beat read (AR→R) or write (AW+W→B) transaction, tags fetches with `m_is_instr`, and returns data, bus error or MMU exception to the originator. Only one transaction is ever outstanding.

---
 rtl/mem_arb_pkg.sv | 45 ++++
 rtl/mem_arbiter_if.sv | 77 +++++++
 rtl/mem_arb_grant.sv | 49 ++++
 rtl/mem_arbiter.sv | 170 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 385 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory-port arbiter.
package mem_arb_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned RESP_W = 2;
  localparam int unsigned EXC_W  = 3;

  localparam logic [RESP_W-1:0] RESP_OKAY = 2'b00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_WR_ADDR,
    ST_WR_RESP
  } state_e;

  typedef enum logic {
    SRC_I = 1'b0,
    SRC_D = 1'b1
  } src_e;

  // Latched request payload, held for the life of the transaction.
  typedef struct packed {
    src_e              src;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
  } req_t;

  // Response payload presented alongside the resp_valid pulse.
  typedef struct packed {
    logic [DATA_W-1:0] rdata;
    logic              err;
    logic              exc;
    logic [EXC_W-1:0]  exc_vec;
  } resp_t;

  function automatic src_e other_src(input src_e s);
    return (s == SRC_I) ? SRC_D : SRC_I;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side and AXI-lite/MMU-side bundles for mem_arbiter.
interface mem_req_if;
  logic                              i_req_valid;
  logic                              i_req_ready;
  logic [mem_arb_pkg::ADDR_W-1:0]    i_req_addr;
  logic                              d_req_valid;
  logic                              d_req_ready;
  logic [mem_arb_pkg::ADDR_W-1:0]    d_req_addr;
  logic                              d_req_we;
  logic [mem_arb_pkg::DATA_W-1:0]    d_req_wdata;
  logic [mem_arb_pkg::STRB_W-1:0]    d_req_wstrb;
  logic                              i_resp_valid;
  logic                              d_resp_valid;
  logic [mem_arb_pkg::DATA_W-1:0]    resp_rdata;
  logic                              resp_err;
  logic                              resp_exc;
  logic [mem_arb_pkg::EXC_W-1:0]     resp_exc_vec;

  // Requesters (fetch and load/store units).
  modport master (
    output i_req_valid, i_req_addr,
    output d_req_valid, d_req_addr, d_req_we, d_req_wdata, d_req_wstrb,
    input  i_req_ready, d_req_ready,
    input  i_resp_valid, d_resp_valid, resp_rdata, resp_err, resp_exc, resp_exc_vec
  );

  // Arbiter.
  modport slave (
    input  i_req_valid, i_req_addr,
    input  d_req_valid, d_req_addr, d_req_we, d_req_wdata, d_req_wstrb,
    output i_req_ready, d_req_ready,
    output i_resp_valid, d_resp_valid, resp_rdata, resp_err, resp_exc, resp_exc_vec
  );
endinterface

interface mem_axil_if;
  logic [mem_arb_pkg::ADDR_W-1:0]    m_axi_araddr;
  logic                              m_axi_arvalid;
  logic                              m_axi_arready;
  logic [mem_arb_pkg::DATA_W-1:0]    m_axi_rdata;
  logic [mem_arb_pkg::RESP_W-1:0]    m_axi_rresp;
  logic                              m_axi_rvalid;
  logic                              m_axi_rready;
  logic [mem_arb_pkg::ADDR_W-1:0]    m_axi_awaddr;
  logic                              m_axi_awvalid;
  logic                              m_axi_awready;
  logic [mem_arb_pkg::DATA_W-1:0]    m_axi_wdata;
  logic [mem_arb_pkg::STRB_W-1:0]    m_axi_wstrb;
  logic                              m_axi_wvalid;
  logic                              m_axi_wready;
  logic [mem_arb_pkg::RESP_W-1:0]    m_axi_bresp;
  logic                              m_axi_bvalid;
  logic                              m_axi_bready;
  logic                              m_is_instr;
  logic                              m_throw_exception;
  logic [mem_arb_pkg::EXC_W-1:0]     m_exception_vec;

  // Arbiter side of the single AXI-lite port.
  modport master (
    output m_axi_araddr, m_axi_arvalid, m_axi_rready,
    output m_axi_awaddr, m_axi_awvalid, m_axi_wdata, m_axi_wstrb, m_axi_wvalid, m_axi_bready,
    output m_is_instr,
    input  m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rvalid,
    input  m_axi_awready, m_axi_wready, m_axi_bresp, m_axi_bvalid,
    input  m_throw_exception, m_exception_vec
  );

  // MMU / memory side.
  modport slave (
    input  m_axi_araddr, m_axi_arvalid, m_axi_rready,
    input  m_axi_awaddr, m_axi_awvalid, m_axi_wdata, m_axi_wstrb, m_axi_wvalid, m_axi_bready,
    input  m_is_instr,
    output m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rvalid,
    output m_axi_awready, m_axi_wready, m_axi_bresp, m_axi_bvalid,
    output m_throw_exception, m_exception_vec
  );
endinterface

// File: rtl/mem_arb_grant.sv
// Combinational requester grant; MEM_ARB_RR_EN adds a round-robin preference register,
// otherwise data always wins over fetch.
module mem_arb_grant
  import mem_arb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_fetch_valid,
  input  logic i_data_valid,
  input  logic i_accept,
  output src_e o_grant_c,
  output logic o_any_c
);

`ifdef MEM_ARB_RR_EN
  // Requester preferred on a tie; flips away from whoever was just accepted.
  src_e r_prio;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prio <= SRC_D;
    end else if (i_accept) begin
      r_prio <= other_src(o_grant_c);
    end
  end

  always_comb begin
    o_grant_c = SRC_D;
    if (i_fetch_valid && i_data_valid) begin
      o_grant_c = r_prio;
    end else if (i_fetch_valid) begin
      o_grant_c = SRC_I;
    end
  end
`else
  logic w_unused;
  assign w_unused = &{1'b0, clk, rst, i_accept};

  always_comb begin
    o_grant_c = SRC_D;
    if (i_fetch_valid && !i_data_valid) begin
      o_grant_c = SRC_I;
    end
  end
`endif

  assign o_any_c = i_fetch_valid | i_data_valid;

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (fetch / load-store) arbiter onto one AXI-lite master port, one
// transaction outstanding. Optional MEM_ARB_RR_EN selects round-robin arbitration.
module mem_arbiter
  import mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  mem_req_if.slave   req,
  mem_axil_if.master axi
);

  state_e r_state;
  req_t   r_req;
  resp_t  r_resp;
  logic   r_is_instr;
  logic   r_i_resp_valid;
  logic   r_d_resp_valid;
  logic   r_arvalid;
  logic   r_rready;
  logic   r_awvalid;
  logic   r_wvalid;
  logic   r_bready;

  src_e   w_grant;
  logic   w_any;
  logic   w_idle_ok;
  logic   w_accept;
  logic   w_new_we;
  req_t   w_new_req;
  logic   w_exc;
  logic   w_rd_done;
  logic   w_wr_done;
  logic   w_finish;
  logic   w_aw_done;
  logic   w_w_done;
  resp_t  w_resp_nxt;

  mem_arb_grant u_grant (
    .clk           (clk),
    .rst           (rst),
    .i_fetch_valid (req.i_req_valid),
    .i_data_valid  (req.d_req_valid),
    .i_accept      (w_accept),
    .o_grant_c     (w_grant),
    .o_any_c       (w_any)
  );

  // Requests are only taken in IDLE and never during the response pulse.
  assign w_idle_ok = (r_state == ST_IDLE) && !r_i_resp_valid && !r_d_resp_valid;
  assign w_accept  = w_idle_ok && w_any;
  assign w_new_we  = req.d_req_we && (w_grant == SRC_D);

  always_comb begin
    w_new_req      = '0;
    w_new_req.src  = w_grant;
    w_new_req.addr = req.i_req_addr;
    if (w_grant == SRC_D) begin
      w_new_req.addr  = req.d_req_addr;
      w_new_req.wdata = req.d_req_wdata;
      w_new_req.wstrb = req.d_req_wstrb;
    end
  end

  // Completion detection; an MMU abort overrides a same-cycle R/B handshake.
  always_comb begin
    w_exc      = (r_state != ST_IDLE) && axi.m_throw_exception;
    w_rd_done  = (r_state == ST_RD_DATA) && r_rready && axi.m_axi_rvalid;
    w_wr_done  = (r_state == ST_WR_RESP) && r_bready && axi.m_axi_bvalid;
    w_finish   = w_exc || w_rd_done || w_wr_done;
    w_aw_done  = !r_awvalid || axi.m_axi_awready;
    w_w_done   = !r_wvalid  || axi.m_axi_wready;
    w_resp_nxt = '0;
    if (w_exc) begin
      w_resp_nxt.exc     = 1'b1;
      w_resp_nxt.exc_vec = axi.m_exception_vec;
    end else if (w_rd_done) begin
      w_resp_nxt.rdata = axi.m_axi_rdata;
      w_resp_nxt.err   = (axi.m_axi_rresp != RESP_OKAY);
    end else if (w_wr_done) begin
      w_resp_nxt.err   = (axi.m_axi_bresp != RESP_OKAY);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_req          <= '0;
      r_resp         <= '0;
      r_is_instr     <= 1'b0;
      r_i_resp_valid <= 1'b0;
      r_d_resp_valid <= 1'b0;
      r_arvalid      <= 1'b0;
      r_rready       <= 1'b0;
      r_awvalid      <= 1'b0;
      r_wvalid       <= 1'b0;
      r_bready       <= 1'b0;
    end else begin
      r_i_resp_valid <= w_finish && (r_req.src == SRC_I);
      r_d_resp_valid <= w_finish && (r_req.src == SRC_D);
      if (w_finish) begin
        r_resp    <= w_resp_nxt;
        r_state   <= ST_IDLE;
        r_arvalid <= 1'b0;
        r_rready  <= 1'b0;
        r_awvalid <= 1'b0;
        r_wvalid  <= 1'b0;
        r_bready  <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_accept) begin
              r_req      <= w_new_req;
              r_is_instr <= (w_grant == SRC_I);
              if (w_new_we) begin
                r_awvalid <= 1'b1;
                r_wvalid  <= 1'b1;
                r_state   <= ST_WR_ADDR;
              end else begin
                r_arvalid <= 1'b1;
                r_state   <= ST_RD_ADDR;
              end
            end
          end
          ST_RD_ADDR: begin
            if (axi.m_axi_arready) begin
              r_arvalid <= 1'b0;
              r_rready  <= 1'b1;
              r_state   <= ST_RD_DATA;
            end
          end
          ST_RD_DATA: begin
          end
          // AW and W complete independently; B is opened once both are through.
          ST_WR_ADDR: begin
            if (axi.m_axi_awready) r_awvalid <= 1'b0;
            if (axi.m_axi_wready)  r_wvalid  <= 1'b0;
            if (w_aw_done && w_w_done) begin
              r_bready <= 1'b1;
              r_state  <= ST_WR_RESP;
            end
          end
          ST_WR_RESP: begin
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign req.i_req_ready  = w_accept && (w_grant == SRC_I);
  assign req.d_req_ready  = w_accept && (w_grant == SRC_D);
  assign req.i_resp_valid = r_i_resp_valid;
  assign req.d_resp_valid = r_d_resp_valid;
  assign req.resp_rdata   = r_resp.rdata;
  assign req.resp_err     = r_resp.err;
  assign req.resp_exc     = r_resp.exc;
  assign req.resp_exc_vec = r_resp.exc_vec;

  assign axi.m_axi_araddr  = r_req.addr;
  assign axi.m_axi_arvalid = r_arvalid;
  assign axi.m_axi_rready  = r_rready;
  assign axi.m_axi_awaddr  = r_req.addr;
  assign axi.m_axi_awvalid = r_awvalid;
  assign axi.m_axi_wdata   = r_req.wdata;
  assign axi.m_axi_wstrb   = r_req.wstrb;
  assign axi.m_axi_wvalid  = r_wvalid;
  assign axi.m_axi_bready  = r_bready;
  assign axi.m_is_instr    = r_is_instr;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic
// against a transaction-level model of grant, handshake timing and response routing.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_req_if  rq ();
  mem_axil_if ax ();

  mem_arbiter dut (
    .clk (clk),
    .rst (rst),
    .req (rq),
    .axi (ax)
  );

  int checks = 0;
  int errors = 0;
  bit pref_d = 1'b1;
  bit prev_pulse = 1'b0;

  typedef struct {
    bit          iv, dv, we, exc;
    logic [31:0] iaddr, daddr, wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  resp;
    logic [2:0]  vec;
    int          ar_dly, r_dly, aw_dly, w_dly, b_dly;
  } txn_t;

  task automatic clear_inputs();
    rq.i_req_valid = 0; rq.i_req_addr = '0;
    rq.d_req_valid = 0; rq.d_req_addr = '0; rq.d_req_we = 0;
    rq.d_req_wdata = '0; rq.d_req_wstrb = '0;
    ax.m_axi_arready = 0; ax.m_axi_rdata = '0; ax.m_axi_rresp = '0; ax.m_axi_rvalid = 0;
    ax.m_axi_awready = 0; ax.m_axi_wready = 0; ax.m_axi_bresp = '0; ax.m_axi_bvalid = 0;
    ax.m_throw_exception = 0; ax.m_exception_vec = '0;
  endtask

  task automatic idle(input int n);
    bit extra;
    extra = 0;
    repeat (n) begin
      @(negedge clk);
      if (rq.i_resp_valid || rq.d_resp_valid) extra = 1;
    end
    checks++;
    if (extra) begin
      errors++; $display("FAIL no_extra_pulse: response valid seen while idle");
    end
    prev_pulse = 0;
  endtask

  // Drives one request, plays the AXI slave with the given delays, checks everything.
  task automatic run_txn(input txn_t t, output bit got_i);
    bit got, gi, wr, ar_d, aw_d, w_d, dn, seen, proto_ok, stable_ok;
    int waited, ar_c, aw_c, w_c, r_c, b_c, exp_k;
    logic [31:0] ea, exp_rdata, cur_addr;
    logic exp_err;
    logic [2:0] exp_vec;
    got = 0; waited = 0; got_i = 0;
    rq.i_req_valid = t.iv; rq.i_req_addr = t.iaddr;
    rq.d_req_valid = t.dv; rq.d_req_addr = t.daddr; rq.d_req_we = t.we;
    rq.d_req_wdata = t.wdata; rq.d_req_wstrb = t.wstrb;
    for (int c = 0; c < 8 && !got; c++) begin
      #1;
      if (rq.i_req_ready || rq.d_req_ready) got = 1;
      else begin @(negedge clk); waited++; end
    end
    checks++;
    if (!got || waited != (prev_pulse ? 1 : 0)) begin
      errors++;
      $display("FAIL accept_wait: accepted=%0b waited=%0d required %0d", got, waited, prev_pulse ? 1 : 0);
    end
    prev_pulse = 0;
    if (!got) begin
      rq.i_req_valid = 0; rq.d_req_valid = 0;
      return;
    end
    gi = (t.iv && !t.dv) ? 1'b1 : (t.dv && !t.iv) ? 1'b0 : (RR ? !pref_d : 1'b0);
    got_i = rq.i_req_ready;
    checks++;
    if (rq.i_req_ready !== gi || rq.d_req_ready !== !gi) begin
      errors++;
      $display("FAIL grant: i_ready=%b d_ready=%b required i=%b d=%b", rq.i_req_ready, rq.d_req_ready, gi, !gi);
    end
    pref_d = gi;
    wr = !gi && t.we;
    ea = gi ? t.iaddr : t.daddr;
    exp_rdata = (t.exc || wr) ? 32'h0 : t.rdata;
    exp_err = !t.exc && (t.resp != 2'b00);
    exp_vec = t.exc ? t.vec : 3'd0;
    @(posedge clk);
    @(negedge clk);
    rq.i_req_valid = 0; rq.d_req_valid = 0;
    ar_d = 0; aw_d = 0; w_d = 0; dn = 0; seen = 0; proto_ok = 1; stable_ok = 1;
    ar_c = 0; aw_c = 0; w_c = 0; r_c = 0; b_c = 0; exp_k = -1;
    for (int k = 1; k <= 40 && !seen; k++) begin
      cur_addr = wr ? ax.m_axi_awaddr : ax.m_axi_araddr;
      if (k == 1) begin
        checks++;
        if ({ax.m_axi_arvalid, ax.m_axi_awvalid, ax.m_axi_wvalid} !== (wr ? 3'b011 : 3'b100)) begin
          errors++;
          $display("FAIL issue: ar/aw/w valid=%b required %b", {ax.m_axi_arvalid, ax.m_axi_awvalid, ax.m_axi_wvalid}, wr ? 3'b011 : 3'b100);
        end
        checks++;
        if (ax.m_is_instr !== gi) begin
          errors++; $display("FAIL is_instr: got %b required %b", ax.m_is_instr, gi);
        end
        checks++;
        if (cur_addr !== ea) begin
          errors++; $display("FAIL addr: got %h required %h", cur_addr, ea);
        end
        if (wr) begin
          checks++;
          if (ax.m_axi_wdata !== t.wdata || ax.m_axi_wstrb !== t.wstrb) begin
            errors++;
            $display("FAIL wpayload: got %h/%h required %h/%h", ax.m_axi_wdata, ax.m_axi_wstrb, t.wdata, t.wstrb);
          end
        end
      end
      if (ax.m_is_instr !== gi || cur_addr !== ea) stable_ok = 0;
      if (rq.i_resp_valid || rq.d_resp_valid) begin
        seen = 1;
        checks++;
        if (k != exp_k) begin
          errors++; $display("FAIL resp_latency: pulse at +%0d required +%0d", k, exp_k);
        end
        checks++;
        if (rq.i_resp_valid !== gi || rq.d_resp_valid !== !gi) begin
          errors++;
          $display("FAIL resp_route: i=%b d=%b required i=%b d=%b", rq.i_resp_valid, rq.d_resp_valid, gi, !gi);
        end
        checks++;
        if (rq.resp_rdata !== exp_rdata) begin
          errors++; $display("FAIL resp_rdata: got %h required %h", rq.resp_rdata, exp_rdata);
        end
        checks++;
        if ({rq.resp_err, rq.resp_exc, rq.resp_exc_vec} !== {exp_err, t.exc, exp_vec}) begin
          errors++;
          $display("FAIL resp_status: err/exc/vec=%b/%b/%0d required %b/%b/%0d", rq.resp_err, rq.resp_exc, rq.resp_exc_vec, exp_err, t.exc, exp_vec);
        end
        checks++;
        if ({ax.m_axi_arvalid, ax.m_axi_rready, ax.m_axi_awvalid, ax.m_axi_wvalid, ax.m_axi_bready} !== 5'b0) begin
          errors++;
          $display("FAIL quiet_after_done: ar/r/aw/w/b=%b required 00000", {ax.m_axi_arvalid, ax.m_axi_rready, ax.m_axi_awvalid, ax.m_axi_wvalid, ax.m_axi_bready});
        end
        checks++;
        if (!proto_ok) begin
          errors++; $display("FAIL handshake_protocol: valid/ready sequencing broken, got 0 required 1");
        end
        checks++;
        if (!stable_ok) begin
          errors++; $display("FAIL addr_stable: address/is_instr changed mid-transaction, got 0 required 1");
        end
      end else if (wr) begin
        if (ax.m_axi_arvalid || ax.m_axi_rready || (ax.m_axi_awvalid !== !aw_d) ||
            (ax.m_axi_wvalid !== !w_d) || (ax.m_axi_bready !== (aw_d && w_d && !dn))) proto_ok = 0;
      end else begin
        if (ax.m_axi_awvalid || ax.m_axi_wvalid || ax.m_axi_bready ||
            (ax.m_axi_arvalid !== !ar_d) || (ax.m_axi_rready !== (ar_d && !dn))) proto_ok = 0;
      end
      ax.m_axi_arready = 0; ax.m_axi_awready = 0; ax.m_axi_wready = 0;
      ax.m_axi_rvalid = 0; ax.m_axi_bvalid = 0; ax.m_throw_exception = 0;
      if (!seen) begin
        if (!wr) begin
          if (!ar_d) begin
            if (ar_c >= t.ar_dly) begin ax.m_axi_arready = 1; ar_d = 1; end
            ar_c++;
          end else if (ax.m_axi_rready && !dn) begin
            if (r_c >= t.r_dly) begin
              ax.m_axi_rvalid = 1; ax.m_axi_rdata = t.rdata; ax.m_axi_rresp = t.resp;
              ax.m_throw_exception = t.exc; ax.m_exception_vec = t.vec;
              dn = 1; exp_k = k + 1;
            end
            r_c++;
          end
        end else begin
          if (ax.m_axi_bready && !dn) begin
            if (b_c >= t.b_dly) begin
              ax.m_axi_bvalid = 1; ax.m_axi_bresp = t.resp;
              ax.m_throw_exception = t.exc; ax.m_exception_vec = t.vec;
              dn = 1; exp_k = k + 1;
            end
            b_c++;
          end
          if (!aw_d) begin
            if (aw_c >= t.aw_dly) begin ax.m_axi_awready = 1; aw_d = 1; end
            aw_c++;
          end
          if (!w_d) begin
            if (w_c >= t.w_dly) begin ax.m_axi_wready = 1; w_d = 1; end
            w_c++;
          end
        end
        @(negedge clk);
      end
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL resp_timeout: no response pulse within 40 cycles, got 0 required 1");
    end
    prev_pulse = seen;
  endtask

  task automatic test_reset();
    checks++;
    if ({ax.m_axi_arvalid, ax.m_axi_rready, ax.m_axi_awvalid, ax.m_axi_wvalid, ax.m_axi_bready} !== 5'b0) begin
      errors++; $display("FAIL reset_axi_valids: got %b required 00000", {ax.m_axi_arvalid, ax.m_axi_rready, ax.m_axi_awvalid, ax.m_axi_wvalid, ax.m_axi_bready});
    end
    checks++;
    if ({rq.i_resp_valid, rq.d_resp_valid} !== 2'b00) begin
      errors++; $display("FAIL reset_resp_valid: got %b required 00", {rq.i_resp_valid, rq.d_resp_valid});
    end
    checks++;
    if ({rq.resp_rdata, rq.resp_err, rq.resp_exc, rq.resp_exc_vec} !== '0) begin
      errors++; $display("FAIL reset_resp_data: got rdata=%h err=%b exc=%b vec=%0d required zeros", rq.resp_rdata, rq.resp_err, rq.resp_exc, rq.resp_exc_vec);
    end
    checks++;
    if (ax.m_is_instr !== 1'b0) begin
      errors++; $display("FAIL reset_is_instr: got %b required 0", ax.m_is_instr);
    end
  endtask

  task automatic test_arbitration();
    txn_t t;
    bit g;
    logic [2:0] seq;
    seq = '0;
    for (int r = 0; r < 3; r++) begin
      t = '{default: 0};
      t.iv = 1; t.dv = 1; t.iaddr = 32'h100 + 32'(r * 4); t.daddr = 32'h200 + 32'(r * 4);
      t.rdata = 32'hA0 + 32'(r);
      run_txn(t, g);
      seq[r] = g;
      idle(1);
    end
    checks++;
    if (seq !== (RR ? 3'b010 : 3'b000)) begin
      errors++; $display("FAIL arb_sequence: fetch-grant bits %b required %b", seq, RR ? 3'b010 : 3'b000);
    end
  endtask

  task automatic test_fetch_read();
    txn_t t;
    bit g;
    t = '{default: 0};
    t.iv = 1; t.iaddr = 32'h0000_1000; t.rdata = 32'hDEAD_BEEF;
    run_txn(t, g);
    idle(2);
  endtask

  task automatic test_data_write();
    txn_t t;
    bit g;
    t = '{default: 0};
    t.dv = 1; t.we = 1; t.daddr = 32'h0000_2000; t.wdata = 32'h1234_5678; t.wstrb = 4'h3;
    t.aw_dly = 0; t.w_dly = 2; t.b_dly = 1;
    run_txn(t, g);
    idle(2);
  endtask

  task automatic test_rresp_err();
    txn_t t;
    bit g;
    t = '{default: 0};
    t.dv = 1; t.daddr = 32'h0000_3004; t.rdata = 32'hCAFE_0001; t.resp = 2'd2; t.r_dly = 1;
    run_txn(t, g);
    idle(1);
  endtask

  task automatic test_exception();
    txn_t t;
    bit g;
    t = '{default: 0};
    t.dv = 1; t.daddr = 32'h0000_4000; t.rdata = 32'h5555_AAAA; t.exc = 1; t.vec = 3'd5;
    run_txn(t, g);
    idle(1);
  endtask

  task automatic test_back_to_back();
    txn_t t;
    bit g;
    for (int n = 0; n < 4; n++) begin
      t = '{default: 0};
      t.iv = n[0]; t.dv = !n[0]; t.we = n[1];
      t.iaddr = 32'h5000 + 32'(n * 16); t.daddr = 32'h6000 + 32'(n * 16);
      t.wdata = $urandom; t.wstrb = 4'hF; t.rdata = $urandom;
      run_txn(t, g);
    end
    idle(1);
  endtask

  task automatic test_random();
    txn_t t;
    bit g;
    for (int n = 0; n < 40; n++) begin
      t = '{default: 0};
      t.iv = $urandom_range(0, 1);
      t.dv = t.iv ? 1'($urandom_range(0, 1)) : 1'b1;
      t.we = 1'($urandom_range(0, 1));
      t.iaddr = $urandom & 32'hFFFF_FFFC; t.daddr = $urandom & 32'hFFFF_FFFC;
      t.wdata = $urandom; t.wstrb = 4'($urandom_range(0, 15)); t.rdata = $urandom;
      t.resp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      t.exc = ($urandom_range(0, 7) == 0);
      t.vec = 3'($urandom_range(0, 7));
      t.ar_dly = $urandom_range(0, 3); t.r_dly = $urandom_range(0, 3);
      t.aw_dly = $urandom_range(0, 3); t.w_dly = $urandom_range(0, 3); t.b_dly = $urandom_range(0, 3);
      run_txn(t, g);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
    end
    idle(1);
  endtask

  task automatic test_reset_mid();
    bit got;
    bit seen;
    got = 0;
    rq.d_req_valid = 1; rq.d_req_we = 1; rq.d_req_addr = 32'h0000_7000;
    rq.d_req_wdata = 32'hFEED_F00D; rq.d_req_wstrb = 4'hF;
    for (int c = 0; c < 4 && !got; c++) begin
      #1;
      if (rq.d_req_ready) got = 1; else @(negedge clk);
    end
    @(posedge clk);
    @(negedge clk);
    rq.d_req_valid = 0;
    ax.m_axi_awready = 1; ax.m_axi_wready = 1;
    @(negedge clk);
    ax.m_axi_awready = 0; ax.m_axi_wready = 0;
    checks++;
    if (!got || ax.m_axi_bready !== 1'b1) begin
      errors++; $display("FAIL reset_mid_reach_wresp: accepted=%0b bready=%b required 1/1", got, ax.m_axi_bready);
    end
    rst = 1; ax.m_axi_bvalid = 1; ax.m_axi_bresp = 2'd0;
    @(negedge clk);
    rst = 0; ax.m_axi_bvalid = 0;
    pref_d = 1; prev_pulse = 0;
    checks++;
    if ({ax.m_axi_arvalid, ax.m_axi_rready, ax.m_axi_awvalid, ax.m_axi_wvalid, ax.m_axi_bready, ax.m_is_instr} !== 6'b0) begin
      errors++; $display("FAIL reset_mid_axi: got %b required 000000", {ax.m_axi_arvalid, ax.m_axi_rready, ax.m_axi_awvalid, ax.m_axi_wvalid, ax.m_axi_bready, ax.m_is_instr});
    end
    checks++;
    if ({rq.resp_rdata, rq.resp_err, rq.resp_exc, rq.resp_exc_vec} !== '0) begin
      errors++; $display("FAIL reset_mid_resp_data: got rdata=%h err=%b exc=%b required zeros", rq.resp_rdata, rq.resp_err, rq.resp_exc);
    end
    seen = rq.i_resp_valid || rq.d_resp_valid;
    @(negedge clk);
    seen = seen || rq.i_resp_valid || rq.d_resp_valid;
    checks++;
    if (seen) begin
      errors++; $display("FAIL reset_mid_no_resp: response pulse after reset, got 1 required 0");
    end
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    repeat (3) @(negedge clk);
    test_reset();
    rst = 0;
    @(negedge clk);
    test_arbitration();
    test_fetch_read();
    test_data_write();
    test_rresp_err();
    test_exception();
    test_back_to_back();
    test_random();
    test_reset_mid();
    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
